// File: rtl/botsw_ireplica_ocp_ctrl.sv
// botsw_ireplica_ocp_ctrl
// Bottom-switch replica current-sense controller: gates the PWM command to
// the bottom driver, blanks the turn-on edge, trips on debounced overcurrent,
// retries after a timed off period and latches off after repeated trips.
// The per-pulse peak replica code is reported at the end of each pulse.
// Optional feature macro: BOTSW_OCP_ZCD_EN adds diode-emulation zero-cross
// turn-off (zc_thresh input, zc_off output).
module botsw_ireplica_ocp_ctrl #(
  parameter int W         = 8,
  parameter int BLANK_CYC = 16,
  parameter int DEB_CNT   = 3,
  parameter int RETRY_CYC = 1024,
  parameter int MAX_RETRY = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         gate_req,
  input  logic         isense_valid,
  input  logic [W-1:0] isense_code,
  input  logic [W-1:0] oc_limit,
  input  logic         fault_clr,
`ifdef BOTSW_OCP_ZCD_EN
  input  logic [W-1:0] zc_thresh,
  output logic         zc_off,
`endif
  output logic         gate_en,
  output logic         oc_fault,
  output logic         latched,
  output logic [3:0]   fault_cnt,
  output logic [W-1:0] ipeak,
  output logic         ipeak_valid
);

  localparam int BW = $clog2(BLANK_CYC + 1);
  localparam int DW = $clog2(DEB_CNT + 1);
  localparam int RW = $clog2(RETRY_CYC + 1);
  localparam logic [BW-1:0] BLANK_LD = BW'(BLANK_CYC);
  localparam logic [DW-1:0] DEB_LD   = DW'(DEB_CNT);
  localparam logic [RW-1:0] RETRY_LD = RW'(RETRY_CYC);
  localparam logic [3:0]    MAX_LD   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BLANK = 3'd1,
    SENSE = 3'd2,
    TRIP  = 3'd3,
    RETRY = 3'd4,
    LATCH = 3'd5
  } state_t;

  state_t         state;
  logic           gate_req_q;
  logic [BW-1:0]  blank_cnt;
  logic [DW-1:0]  deb_cnt;
  logic [RW-1:0]  retry_cnt;
  logic [W-1:0]   limit_q;
  logic [W-1:0]   peak;

  logic           rise;
  logic           over;
  logic [DW-1:0]  deb_inc;
  logic           trip_hit;
  logic           zc_hit;
  logic [W-1:0]   peak_next;
  logic [3:0]     fault_inc;

  // Per-cycle decode of the current sample against the captured limit
  always_comb begin
    rise      = gate_req && !gate_req_q;
    over      = (isense_code >= limit_q);
    deb_inc   = deb_cnt + DW'(1);
    trip_hit  = isense_valid && over && (deb_inc == DEB_LD);
    peak_next = (isense_valid && (isense_code > peak)) ? isense_code : peak;
    fault_inc = (fault_cnt == 4'hF) ? fault_cnt : fault_cnt + 4'd1;
`ifdef BOTSW_OCP_ZCD_EN
    zc_hit    = isense_valid && (isense_code <= zc_thresh);
`else
    zc_hit    = 1'b0;
`endif
  end

  // Protection state machine with registered gate and status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      gate_req_q  <= 1'b1;
      blank_cnt   <= '0;
      deb_cnt     <= '0;
      retry_cnt   <= '0;
      limit_q     <= '0;
      peak        <= '0;
      gate_en     <= 1'b0;
      oc_fault    <= 1'b0;
      latched     <= 1'b0;
      fault_cnt   <= 4'd0;
      ipeak       <= '0;
      ipeak_valid <= 1'b0;
`ifdef BOTSW_OCP_ZCD_EN
      zc_off      <= 1'b0;
`endif
    end else begin
      gate_req_q  <= gate_req;
      ipeak_valid <= 1'b0;
`ifdef BOTSW_OCP_ZCD_EN
      zc_off      <= 1'b0;
`endif
      if (!enable) begin
        state     <= IDLE;
        gate_en   <= 1'b0;
        oc_fault  <= 1'b0;
        latched   <= 1'b0;
        fault_cnt <= 4'd0;
        blank_cnt <= '0;
        deb_cnt   <= '0;
        retry_cnt <= '0;
      end else begin
        if (fault_clr) begin
          fault_cnt <= 4'd0;
          oc_fault  <= 1'b0;
        end
        case (state)
          IDLE: begin
            gate_en <= 1'b0;
            if (rise) begin
              state     <= BLANK;
              gate_en   <= 1'b1;
              blank_cnt <= BLANK_LD;
              limit_q   <= oc_limit;
              peak      <= '0;
              deb_cnt   <= '0;
            end
          end
          BLANK: begin
            if (!gate_req) begin
              state   <= IDLE;
              gate_en <= 1'b0;
            end else if (blank_cnt <= BW'(1)) begin
              state     <= SENSE;
              blank_cnt <= '0;
            end else begin
              blank_cnt <= blank_cnt - BW'(1);
            end
          end
          SENSE: begin
            if (isense_valid) begin
              peak    <= peak_next;
              deb_cnt <= over ? deb_inc : '0;
            end
            if (trip_hit) begin
              state       <= TRIP;
              gate_en     <= 1'b0;
              oc_fault    <= 1'b1;
              fault_cnt   <= fault_inc;
              ipeak       <= peak_next;
              ipeak_valid <= 1'b1;
              deb_cnt     <= '0;
            end else if (zc_hit || !gate_req) begin
              state       <= IDLE;
              gate_en     <= 1'b0;
              ipeak       <= peak_next;
              ipeak_valid <= 1'b1;
              deb_cnt     <= '0;
`ifdef BOTSW_OCP_ZCD_EN
              zc_off      <= zc_hit;
`endif
            end
          end
          TRIP: begin
            gate_en <= 1'b0;
            if (!fault_clr && (fault_cnt >= MAX_LD)) begin
              state   <= LATCH;
              latched <= 1'b1;
            end else begin
              state     <= RETRY;
              retry_cnt <= RETRY_LD;
            end
          end
          RETRY: begin
            gate_en <= 1'b0;
            if (retry_cnt <= RW'(1)) begin
              state     <= IDLE;
              retry_cnt <= '0;
            end else begin
              retry_cnt <= retry_cnt - RW'(1);
            end
          end
          LATCH: begin
            gate_en <= 1'b0;
            if (fault_clr) begin
              state   <= IDLE;
              latched <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            gate_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_botsw_ireplica_ocp_ctrl.sv
// tb_botsw_ireplica_ocp_ctrl
// Directed bench for the bottom-switch overcurrent controller using the
// default parameters (BLANK_CYC=16, DEB_CNT=3, RETRY_CYC=1024, MAX_RETRY=4).
// Define BOTSW_OCP_ZCD_EN to also exercise the zero-cross turn-off.
module tb_botsw_ireplica_ocp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       gate_req;
  logic       isense_valid;
  logic [7:0] isense_code;
  logic [7:0] oc_limit;
  logic       fault_clr;
  logic       gate_en;
  logic       oc_fault;
  logic       latched;
  logic [3:0] fault_cnt;
  logic [7:0] ipeak;
  logic       ipeak_valid;
`ifdef BOTSW_OCP_ZCD_EN
  logic [7:0] zc_thresh;
  logic       zc_off;
`endif

  int checkCount = 0;
  int errorCount = 0;

  botsw_ireplica_ocp_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .gate_req     (gate_req),
    .isense_valid (isense_valid),
    .isense_code  (isense_code),
    .oc_limit     (oc_limit),
    .fault_clr    (fault_clr),
`ifdef BOTSW_OCP_ZCD_EN
    .zc_thresh    (zc_thresh),
    .zc_off       (zc_off),
`endif
    .gate_en      (gate_en),
    .oc_fault     (oc_fault),
    .latched      (latched),
    .fault_cnt    (fault_cnt),
    .ipeak        (ipeak),
    .ipeak_valid  (ipeak_valid)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One valid replica sample presented for exactly one edge
  task automatic applyStimulus(input logic [7:0] code);
    isense_valid = 1'b1;
    isense_code  = code;
    tick();
    isense_valid = 1'b0;
  endtask

  // Low-then-high on gate_req; the rise is seen on the second edge
  task automatic pulseOn();
    gate_req = 1'b0;
    tick();
    gate_req = 1'b1;
    tick();
  endtask

  // Turn on, sit out the blanking window and land in SENSE
  task automatic pulseToSense(input logic [7:0] limit);
    oc_limit = limit;
    pulseOn();
    tick(16);
  endtask

  // Turn on and trip with three over-limit samples
  task automatic doTrip();
    pulseToSense(8'd100);
    for (int i = 0; i < 3; i++) applyStimulus(8'd150);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; gate_req = 1'b1; isense_valid = 1'b0;
    isense_code = 8'd0; oc_limit = 8'd100; fault_clr = 1'b0;
`ifdef BOTSW_OCP_ZCD_EN
    zc_thresh = 8'd0;
`endif

    // Reset with gate_req held high
    tick(2);
    checkOutput("rst_gate_en", 32'(gate_en), 0);
    checkOutput("rst_oc_fault", 32'(oc_fault), 0);
    checkOutput("rst_latched", 32'(latched), 0);
    checkOutput("rst_fault_cnt", 32'(fault_cnt), 0);
    checkOutput("rst_ipeak", 32'(ipeak), 0);
    checkOutput("rst_ipeak_valid", 32'(ipeak_valid), 0);
    rst_n = 1'b1;
    tick(3);
    checkOutput("held_high_no_fire", 32'(gate_en), 0);
    pulseOn();
    checkOutput("first_rise_gate_en", 32'(gate_en), 1);

    // Blanking ignores 200s, then 50s in SENSE do not trip
    for (int i = 0; i < 16; i++) applyStimulus(8'd200);
    checkOutput("blank_no_trip", 32'(gate_en), 1);
    for (int i = 0; i < 4; i++) applyStimulus(8'd50);
    checkOutput("sense_50_no_trip", 32'(oc_fault), 0);
    gate_req = 1'b0;
    tick();
    checkOutput("fall_gate_en", 32'(gate_en), 0);
    checkOutput("fall_ipeak", 32'(ipeak), 50);
    checkOutput("fall_ipeak_valid", 32'(ipeak_valid), 1);
    tick();
    checkOutput("ipeak_valid_one_cycle", 32'(ipeak_valid), 0);

    // Debounce: 120,130,90,120,120,120 trips on the sixth sample
    pulseToSense(8'd100);
    applyStimulus(8'd120); applyStimulus(8'd130); applyStimulus(8'd90);
    applyStimulus(8'd120); applyStimulus(8'd120);
    checkOutput("deb_pre_trip_gate_en", 32'(gate_en), 1);
    applyStimulus(8'd120);
    checkOutput("trip_gate_en", 32'(gate_en), 0);
    checkOutput("trip_oc_fault", 32'(oc_fault), 1);
    checkOutput("trip_fault_cnt", 32'(fault_cnt), 1);
    checkOutput("trip_ipeak", 32'(ipeak), 130);
    checkOutput("trip_ipeak_valid", 32'(ipeak_valid), 1);
    tick(500);
    pulseOn();
    checkOutput("retry_blocks_rise", 32'(gate_en), 0);
    tick(600);
    checkOutput("retry_held_high_no_fire", 32'(gate_en), 0);
    pulseOn();
    checkOutput("rearm_gate_en", 32'(gate_en), 1);
    gate_req = 1'b0;
    tick();
    checkOutput("blank_fall_no_ipeak_valid", 32'(ipeak_valid), 0);
    checkOutput("blank_fall_gate_en", 32'(gate_en), 0);

    // Trips two to four lead to latch-off
    doTrip();
    checkOutput("trip2_fault_cnt", 32'(fault_cnt), 2);
    tick(1100);
    doTrip();
    checkOutput("trip3_fault_cnt", 32'(fault_cnt), 3);
    tick(1100);
    doTrip();
    checkOutput("trip4_fault_cnt", 32'(fault_cnt), 4);
    tick();
    checkOutput("latched_after_4", 32'(latched), 1);
    tick(1100);
    pulseOn();
    tick();
    checkOutput("latch_ignores_rise", 32'(gate_en), 0);
    checkOutput("latch_holds", 32'(latched), 1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checkOutput("clr_latched", 32'(latched), 0);
    checkOutput("clr_fault_cnt", 32'(fault_cnt), 0);
    checkOutput("clr_oc_fault", 32'(oc_fault), 0);
    pulseOn();
    checkOutput("post_clr_gate_en", 32'(gate_en), 1);

    // Enable dropped mid-SENSE
    tick(16);
    applyStimulus(8'd150); applyStimulus(8'd150);
    enable = 1'b0;
    tick();
    checkOutput("en_low_sense_gate_en", 32'(gate_en), 0);
    enable = 1'b1;

    // Enable dropped mid-RETRY clears flags and the retry wait
    doTrip();
    checkOutput("pre_en_oc_fault", 32'(oc_fault), 1);
    tick(10);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    checkOutput("en_low_retry_oc_fault", 32'(oc_fault), 0);
    checkOutput("en_low_retry_fault_cnt", 32'(fault_cnt), 0);
    pulseOn();
    checkOutput("en_low_retry_rearm", 32'(gate_en), 1);
    gate_req = 1'b0;
    tick();

    // Full-scale boundary: 254 under a 255 limit holds, 255 trips
    pulseToSense(8'd255);
    for (int i = 0; i < 3; i++) applyStimulus(8'd254);
    checkOutput("fs_254_no_trip", 32'(gate_en), 1);
    for (int i = 0; i < 3; i++) applyStimulus(8'd255);
    checkOutput("fs_255_trip", 32'(oc_fault), 1);
    checkOutput("fs_255_ipeak", 32'(ipeak), 255);
    enable = 1'b0; tick(); enable = 1'b1;

    // Zero limit trips on three zero samples after blanking
    pulseToSense(8'd0);
    for (int i = 0; i < 3; i++) applyStimulus(8'd0);
    checkOutput("zero_limit_trip", 32'(oc_fault), 1);
    checkOutput("zero_limit_gate_en", 32'(gate_en), 0);
    enable = 1'b0; tick(); enable = 1'b1;

`ifdef BOTSW_OCP_ZCD_EN
    // Zero-cross turn-off is not a fault
    zc_thresh = 8'd5;
    pulseToSense(8'd100);
    applyStimulus(8'd40);
    applyStimulus(8'd3);
    checkOutput("zc_off_pulse", 32'(zc_off), 1);
    checkOutput("zc_gate_en", 32'(gate_en), 0);
    checkOutput("zc_ipeak", 32'(ipeak), 40);
    checkOutput("zc_fault_cnt", 32'(fault_cnt), 0);
    tick();
    checkOutput("zc_off_one_cycle", 32'(zc_off), 0);
    // Same sample completes debounce and zero-crosses: trip wins
    pulseToSense(8'd2);
    applyStimulus(8'd10); applyStimulus(8'd10); applyStimulus(8'd3);
    checkOutput("zc_vs_trip_oc_fault", 32'(oc_fault), 1);
    checkOutput("zc_vs_trip_zc_off", 32'(zc_off), 0);
    checkOutput("zc_vs_trip_fault_cnt", 32'(fault_cnt), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
